// File: rtl/pulse_transmitter_symbol_gen_if.sv
// Symbol write channel between the register block and the symbol generator.
// The master offers one (level, duration) symbol per cycle with sym_valid;
// the slave accepts it in any cycle where sym_ready is also high.
interface pulse_transmitter_symbol_gen_if #(
    parameter int DUR_W = 8
) ();
    logic             sym_valid;
    logic             sym_level;
    logic [DUR_W-1:0] sym_duration;
    logic             sym_ready;

    modport master (
        output sym_valid,
        output sym_level,
        output sym_duration,
        input  sym_ready
    );

    modport slave (
        input  sym_valid,
        input  sym_level,
        input  sym_duration,
        output sym_ready
    );
endinterface

// File: rtl/pulse_transmitter_symbol_gen.sv
// Pulse transmitter symbol generator: buffers (level, duration) symbols in a
// small FIFO and plays them back as a gap-free, prescaler-timed pulse train.
// Optional feature macro PULSE_TX_LOOP_EN adds cfg_loop, which recirculates
// every played symbol to the FIFO tail so the pattern repeats until stop.
module pulse_transmitter_symbol_gen #(
    parameter int DUR_W      = 8,
    parameter int PRESC_W    = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic               clk,
    input  logic               sys_rst_n,
    input  logic [PRESC_W-1:0] cfg_prescaler,
    input  logic               cfg_idle_level,
`ifdef PULSE_TX_LOOP_EN
    input  logic               cfg_loop,
`endif
    input  logic               start,
    input  logic               stop,
    pulse_transmitter_symbol_gen_if.slave sym_bus,
    output logic               sig_out,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   fifo_count
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, next_state;

    logic             mem_level [FIFO_DEPTH];
    logic [DUR_W-1:0] mem_dur   [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, ext_addr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             head_level;
    logic [DUR_W-1:0] head_dur;

    logic               rst_done;
    logic               cur_level;
    logic [DUR_W-1:0]   cur_dur;
    logic [DUR_W-1:0]   dur_cnt;
    logic [PRESC_W-1:0] presc_reload;
    logic [PRESC_W-1:0] presc_cnt;

    logic tick, expire;
    logic pop, flush, finish, latch_cfg;
    logic push_ext, push_loop;

    assign full       = (count == CNT_W'(FIFO_DEPTH));
    assign head_level = mem_level[rd_ptr];
    assign head_dur   = mem_dur[rd_ptr];
    assign fifo_count = count;

    assign tick   = (presc_cnt == presc_reload);
    assign expire = tick && (dur_cnt == cur_dur);

`ifdef PULSE_TX_LOOP_EN
    logic loop_mode;
    logic loop_next;

    assign loop_next        = latch_cfg ? cfg_loop : loop_mode;
    assign push_loop        = pop && loop_next;
    assign sym_bus.sym_ready = rst_done && !full && !(busy && loop_mode);

    // Loop mode is captured at start so later cfg_loop changes do not matter
    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            loop_mode <= 1'b0;
        end else if (flush) begin
            loop_mode <= 1'b0;
        end else if (latch_cfg) begin
            loop_mode <= cfg_loop;
        end
    end
`else
    assign push_loop         = 1'b0;
    assign sym_bus.sym_ready = rst_done && !full;
`endif

    // A flushing stop discards any write offered in the same cycle
    assign push_ext = sym_bus.sym_valid && sym_bus.sym_ready && !flush;
    // When a recirculated symbol and a new one land together, the new one goes second
    assign ext_addr = push_loop ? (wr_ptr + PTR_W'(1)) : wr_ptr;

    // State register
    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode; stop outranks start, push and expiry
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        flush      = 1'b0;
        finish     = 1'b0;
        latch_cfg  = 1'b0;
        case (state)
            IDLE: begin
                if (stop) begin
                    flush = 1'b1;
                end else if (start && (count != '0)) begin
                    pop        = 1'b1;
                    latch_cfg  = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    flush      = 1'b1;
                    next_state = IDLE;
                end else if (expire) begin
                    if (count != '0) begin
                        pop = 1'b1;
                    end else begin
                        finish     = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Symbol storage; no reset needed since count guards every read
    always_ff @(posedge clk) begin
        if (push_loop) begin
            mem_level[wr_ptr] <= head_level;
            mem_dur[wr_ptr]   <= head_dur;
        end
        if (push_ext) begin
            mem_level[ext_addr] <= sym_bus.sym_level;
            mem_dur[ext_addr]   <= sym_bus.sym_duration;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!sys_rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push_ext) + PTR_W'(push_loop);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + CNT_W'(push_ext) + CNT_W'(push_loop) - CNT_W'(pop);
        end
    end

    // Playback datapath: timing counters, current symbol and registered outputs
    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            rst_done     <= 1'b0;
            sig_out      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cur_level    <= 1'b0;
            cur_dur      <= '0;
            dur_cnt      <= '0;
            presc_cnt    <= '0;
            presc_reload <= '0;
        end else begin
            rst_done <= 1'b1;
            busy     <= (next_state == RUN);
            done     <= finish;
            if (next_state == RUN) begin
                sig_out <= pop ? head_level : cur_level;
            end else begin
                sig_out <= cfg_idle_level;
            end
            if (latch_cfg) begin
                presc_reload <= cfg_prescaler;
            end
            if (pop) begin
                cur_level <= head_level;
                cur_dur   <= head_dur;
                presc_cnt <= '0;
                dur_cnt   <= '0;
            end else if (state == RUN && next_state == RUN) begin
                if (tick) begin
                    presc_cnt <= '0;
                    dur_cnt   <= dur_cnt + DUR_W'(1);
                end else begin
                    presc_cnt <= presc_cnt + PRESC_W'(1);
                end
            end else begin
                presc_cnt <= '0;
                dur_cnt   <= '0;
            end
        end
    end

endmodule
